// File: rtl/mem_port_arbiter.sv
// Arbitrates an instruction-fetch port and a load/store port onto one RAM port with
// a single transaction outstanding; load/store has priority but fetch cannot starve.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MAX_STREAK = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req_valid,
  input  logic [ADDR_W-1:0] if_req_addr,
  output logic              if_req_ready,
  output logic              if_rsp_valid,
  output logic [DATA_W-1:0] if_rsp_data,
  output logic              if_rsp_err,
  input  logic              ls_req_valid,
  input  logic              ls_req_we,
  input  logic [ADDR_W-1:0] ls_req_addr,
  input  logic [DATA_W-1:0] ls_req_wdata,
  output logic              ls_req_ready,
  output logic              ls_rsp_valid,
  output logic [DATA_W-1:0] ls_rsp_data,
  output logic              ls_rsp_err,
  output logic              mem_req_valid,
  output logic              mem_req_we,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [DATA_W-1:0] mem_req_wdata,
  input  logic              mem_req_ready,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rsp_data,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP} state_t;

  localparam int SW = $clog2(MAX_STREAK + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] STREAK_SAT = SW'(MAX_STREAK);
  localparam logic [TW-1:0] TCNT_LAST  = TW'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [SW-1:0]     streak_q, streak_d;
  logic [TW-1:0]     tcnt_q, tcnt_d;
  logic              owner_ls_q, owner_ls_d;
  logic              fetch_win, if_acc, ls_acc, acc_misaligned, load_req;
  logic              rsp_fire, rsp_to_ls, rsp_err;
  logic [DATA_W-1:0] rsp_data;

  // Readies are gated by reset so every output is low while reset is held.
  always_comb begin
    fetch_win    = if_req_valid && (!ls_req_valid || streak_q == STREAK_SAT);
    if_req_ready = !reset && (state_q == IDLE) && fetch_win;
    ls_req_ready = !reset && (state_q == IDLE) && ls_req_valid && !fetch_win;
  end

  assign if_acc         = if_req_valid && if_req_ready;
  assign ls_acc         = ls_req_valid && ls_req_ready;
  assign acc_misaligned = if_acc ? (if_req_addr[1:0] != 2'b00) : (ls_req_addr[1:0] != 2'b00);
  assign mem_req_valid  = (state_q == ISSUE);
  assign busy           = (state_q != IDLE);

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    streak_d   = streak_q;
    tcnt_d     = tcnt_q;
    owner_ls_d = owner_ls_q;
    load_req   = 1'b0;
    rsp_fire   = 1'b0;
    rsp_to_ls  = owner_ls_q;
    rsp_err    = 1'b0;
    rsp_data   = '0;
    case (state_q)
      IDLE: begin
        if (if_acc || !if_req_valid) streak_d = '0;
        else if (ls_acc && streak_q != STREAK_SAT) streak_d = streak_q + 1'b1;
        if (if_acc || ls_acc) begin
          rsp_to_ls = ls_acc;
          // Misaligned requests are answered with an error without touching RAM.
          if (acc_misaligned) begin
            rsp_fire = 1'b1;
            rsp_err  = 1'b1;
          end else begin
            owner_ls_d = ls_acc;
            load_req   = 1'b1;
            state_d    = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (mem_req_ready) begin
          state_d = WAIT_RSP;
          tcnt_d  = '0;
        end
      end
      WAIT_RSP: begin
        if (mem_rsp_valid) begin
          rsp_fire = 1'b1;
          rsp_data = mem_req_we ? '0 : mem_rsp_data;
          state_d  = IDLE;
        end else if (tcnt_q == TCNT_LAST) begin
          rsp_fire = 1'b1;
          rsp_err  = 1'b1;
          state_d  = IDLE;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      streak_q      <= '0;
      tcnt_q        <= '0;
      owner_ls_q    <= 1'b0;
      mem_req_we    <= 1'b0;
      mem_req_addr  <= '0;
      mem_req_wdata <= '0;
      if_rsp_valid  <= 1'b0;
      if_rsp_err    <= 1'b0;
      if_rsp_data   <= '0;
      ls_rsp_valid  <= 1'b0;
      ls_rsp_err    <= 1'b0;
      ls_rsp_data   <= '0;
    end else begin
      state_q    <= state_d;
      streak_q   <= streak_d;
      tcnt_q     <= tcnt_d;
      owner_ls_q <= owner_ls_d;
      if (load_req) begin
        mem_req_we    <= ls_acc && ls_req_we;
        mem_req_addr  <= if_acc ? if_req_addr : ls_req_addr;
        mem_req_wdata <= ls_acc ? ls_req_wdata : '0;
      end
      if_rsp_valid <= rsp_fire && !rsp_to_ls;
      if_rsp_err   <= rsp_fire && !rsp_to_ls && rsp_err;
      if_rsp_data  <= (rsp_fire && !rsp_to_ls) ? rsp_data : '0;
      ls_rsp_valid <= rsp_fire && rsp_to_ls;
      ls_rsp_err   <= rsp_fire && rsp_to_ls && rsp_err;
      ls_rsp_data  <= (rsp_fire && rsp_to_ls) ? rsp_data : '0;
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, address width of all ports.
REQ-002 Parameter DATA_W, default 32, data width of all ports.
REQ-003 Parameter MAX_STREAK, default 4, maximum consecutive load/store grants while fetch waits.
REQ-004 Parameter TIMEOUT, default 16, cycles allowed in WAIT_RSP before an error response.
REQ-005 Ports SHALL be:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- if_req_valid  in  1  fetch request.
- if_req_addr  in  ADDR_W  fetch address.
- if_req_ready  out  1  fetch request accepted.
- if_rsp_valid  out  1  fetch response strobe.
- if_rsp_data  out  DATA_W  fetched word.
- if_rsp_err  out  1  fetch error.
- ls_req_valid  in  1  load/store request.
- ls_req_we  in  1  1 = store, 0 = load.
- ls_req_addr  in  ADDR_W  data address.
- ls_req_wdata  in  DATA_W  store data.
- ls_req_ready  out  1  load/store request accepted.
- ls_rsp_valid  out  1  load/store response strobe.
- ls_rsp_data  out  DATA_W  load data; 0 for stores.
- ls_rsp_err  out  1  load/store error.
- mem_req_valid  out  1  RAM request.
- mem_req_we  out  1  RAM write enable.
- mem_req_addr  out  ADDR_W  RAM address.
- mem_req_wdata  out  DATA_W  RAM write data.
- mem_req_ready  in  1  RAM accepted request.
- mem_rsp_valid  in  1  RAM read data / write acknowledge.
- mem_rsp_data  in  DATA_W  RAM read data.
- busy  out  1  high in any state other than IDLE.

Function
REQ-006 The FSM SHALL have the states IDLE, ISSUE, WAIT_RSP, with at most one transaction outstanding.
REQ-007 if_req_ready and ls_req_ready SHALL be combinational, asserted only in IDLE, and only for the granted requester, so they are mutually exclusive.
REQ-008 Grant rule in IDLE:
- Load/store wins when both requesters are valid.
- Exception: fetch wins if streak == MAX_STREAK and if_req_valid = 1.
REQ-009 The streak counter SHALL increment, saturating at MAX_STREAK, on each load/store grant made while if_req_valid = 1.
REQ-010 The streak counter SHALL clear on a fetch grant, or in any IDLE cycle with if_req_valid = 0.
REQ-011 On acceptance (valid && ready), the block SHALL latch addr, we, wdata and owner, and move to ISSUE on the next edge.
REQ-012 Fetch requests SHALL be treated as loads (we = 0).
REQ-013 Misaligned requests (addr[1:0] != 0):
- No memory access is made.
- The owner's rsp_valid = 1 and err = 1, with data = 0, on the cycle after acceptance.
- The FSM stays in IDLE.
REQ-014 In ISSUE, mem_req_* SHALL be driven from registers and held stable until mem_req_ready = 1; the FSM then moves to WAIT_RSP.
REQ-015 In WAIT_RSP, on mem_rsp_valid, the block SHALL pulse the owner's rsp_valid for exactly one cycle on the next cycle and return to IDLE.
REQ-016 Response data and error in WAIT_RSP:
- rsp_data = registered mem_rsp_data for loads, 0 for stores.
- err = 0.
REQ-017 The timeout counter SHALL clear on entering WAIT_RSP.
REQ-018 If TIMEOUT cycles elapse in WAIT_RSP without mem_rsp_valid, the owner SHALL receive rsp_valid = 1, err = 1 and data = 0, and the FSM returns to IDLE.
REQ-019 mem_rsp_valid SHALL be ignored outside WAIT_RSP (late or stray responses are dropped).
REQ-020 Minimum latency SHALL be 3 cycles, given acceptance at cycle 0, mem_req_ready = 1 at cycle 1 and mem_rsp_valid at cycle 2:
- mem_req_valid at cycle 1.
- rsp_valid at cycle 3.
REQ-021 Outside ISSUE, mem_req_valid SHALL be 0; mem_req_addr, mem_req_wdata and mem_req_we hold their last values.
REQ-022 The non-owner's rsp_valid SHALL never assert.
REQ-023 A new request SHALL be acceptable in the same cycle that the previous rsp_valid is high (FSM already in IDLE).

Reset
REQ-024 While reset = 1, regardless of state, all outputs SHALL be 0, the FSM is IDLE, and the streak and timeout counters are 0.
REQ-025 A transaction in flight at reset SHALL be discarded with no response issued, including a mem_rsp_valid arriving after reset deasserts.
REQ-026 The first request SHALL be accepted on the first clk edge after reset deasserts.

Verification
REQ-027 Single load: ls load addr 0x100 with RAM data 0xDEADBEEF -> mem_req addr 0x100, we = 0; ls_rsp_valid pulse with data 0xDEADBEEF, err = 0, 3 cycles after acceptance.
REQ-028 Contention: if_req_valid and ls_req_valid both held high continuously -> grant order LS,LS,LS,LS,IF,LS,LS,LS,LS,IF...
REQ-029 Store then fetch: store 0x0000_00AA to 0x40 (acked), then fetch 0x0 (data 0x00000013) -> ls_rsp_data = 0; if_rsp_data = 0x00000013; if_rsp_valid never high during the store.
REQ-030 Timeout: load with mem_rsp_valid held 0 -> ls_rsp_err = 1 after 16 cycles in WAIT_RSP; a mem_rsp_valid pulse 2 cycles later produces no response.
REQ-031 Misaligned: fetch addr 0x6 -> if_rsp_err = 1 on the next cycle; mem_req_valid stays 0.
REQ-032 Reset mid-op: reset asserted during WAIT_RSP -> busy = 0 and all rsp_valid = 0 immediately; no response after release.
